// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared types and defaults for the toggle req/ack CDC handshake
package handshake_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } hs_rx_state_e;

  localparam int HS_DEFAULT_CHAIN_LENGTH = 3;

endpackage : handshake_pkg

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchroniser for a single asynchronous level/toggle
module bit_synchronizer
  import handshake_pkg::*;
#(
  parameter int CHAIN_LENGTH = HS_DEFAULT_CHAIN_LENGTH
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic d_i,
  output logic q_o
);

  // The first stage may go metastable; the rest of the chain gives it time to settle.
  (* async_reg = "true" *) logic [CHAIN_LENGTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[CHAIN_LENGTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[CHAIN_LENGTH-1];

endmodule : bit_synchronizer

// File: rtl/handshake_receiver.sv
// rtl/handshake_receiver.sv - destination end of a two-phase req/ack handshake with valid/ready output
module handshake_receiver
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CHAIN_LENGTH   = HS_DEFAULT_CHAIN_LENGTH,
  parameter bit ACK_ON_CAPTURE = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  hs_rx_state_e          state_q, state_d;
  logic                  req_seen_q, req_seen_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_sync;
  logic                  pending;

  bit_synchronizer #(
    .CHAIN_LENGTH(CHAIN_LENGTH)
  ) u_req_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .d_i      (req_i),
    .q_o      (req_sync)
  );

  // A new word is outstanding whenever the synchronised toggle differs from the last one consumed.
  assign pending = req_sync ^ req_seen_q;

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    valid_d    = valid_q;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (pending) begin
          data_d     = data_i;
          valid_d    = 1'b1;
          req_seen_d = ~req_seen_q;
          state_d    = PRESENT;
          if (ACK_ON_CAPTURE) begin
            ack_d = ~ack_q;
          end
        end
      end

      PRESENT: begin
        if (valid_q && ready_i) begin
          if (!ACK_ON_CAPTURE) begin
            ack_d   = ~ack_q;
            valid_d = 1'b0;
            state_d = IDLE;
          end else if (pending) begin
            // Early ack let the source post its next word already; take it on the accept edge.
            data_d     = data_i;
            req_seen_d = ~req_seen_q;
            ack_d      = ~ack_q;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign ack_o   = ack_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule : handshake_receiver

// File: tb/tb_handshake_receiver.sv
// tb/tb_handshake_receiver.sv - self-checking bench for handshake_receiver in both ack modes
module tb_handshake_receiver;

  logic        clk = 1'b0;
  logic        src_clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic [31:0] data_i;
  logic        ready_i;
  logic        ack0, valid0, ack1, valid1;
  logic [31:0] data0, data1;
  logic        mode_sel;
  logic        ack_s, valid_s;
  logic [31:0] data_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  // Source clock edges fall on 4+8k, never on the receiver's 5+10m edges.
  always #4 src_clk = ~src_clk;

  handshake_receiver #(.DATA_WIDTH(32), .CHAIN_LENGTH(3), .ACK_ON_CAPTURE(1'b0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(req_i), .data_i(data_i),
    .ack_o(ack0), .valid_o(valid0), .ready_i(ready_i), .data_o(data0)
  );

  handshake_receiver #(.DATA_WIDTH(32), .CHAIN_LENGTH(3), .ACK_ON_CAPTURE(1'b1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .req_i(req_i), .data_i(data_i),
    .ack_o(ack1), .valid_o(valid1), .ready_i(ready_i), .data_o(data1)
  );

  assign ack_s   = mode_sel ? ack1 : ack0;
  assign valid_s = mode_sel ? valid1 : valid0;
  assign data_s  = mode_sel ? data1 : data0;

  typedef struct {
    logic        req;
    logic [31:0] data;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ack0;
    logic        exp_ack1;
  } vec_t;

  vec_t tbl [15];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req_i   = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input logic which, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(which ? valid1 : valid0) && n < 20);
    chk1("wait_valid", which ? valid1 : valid0, 1'b1);
  endtask

  task automatic run_random(input logic mode, input int nw);
    logic [31:0] exp_q[$];
    int          received;
    int          acks;
    int          cyc;
    logic        abort;
    received = 0;
    acks     = 0;
    cyc      = 0;
    abort    = 1'b0;
    mode_sel = mode;
    do_reset();
    fork
      begin : source
        for (int w = 0; w < nw && !abort; w++) begin
          logic [31:0] word;
          word = $urandom;
          repeat ($urandom_range(0, 3)) @(posedge src_clk);
          @(posedge src_clk);
          data_i = word;
          req_i  = ~req_i;
          exp_q.push_back(word);
          for (int k = 0; k < 400 && ack_s != req_i && !abort; k++) @(posedge src_clk);
          if (ack_s != req_i && !abort) begin
            chk1("rnd_src_ack_timeout", ack_s, req_i);
            abort = 1'b1;
          end
          // Once ack is seen the source may drive anything until its next toggle.
          data_i = $urandom;
        end
      end
      begin : sink
        logic        pv, pr, pa;
        logic [31:0] pd;
        logic [31:0] exp_w;
        while (received < nw && !abort && cyc < nw * 60) begin
          ready_i = ($urandom_range(0, 3) != 0);
          pv = valid_s;
          pr = ready_i;
          pa = ack_s;
          pd = data_s;
          step();
          cyc++;
          if (pv && pr) begin
            if (exp_q.size() == 0) begin
              chk1("rnd_unexpected_word", 1'b1, 1'b0);
            end else begin
              exp_w = exp_q.pop_front();
              chk32("rnd_order", pd, exp_w);
            end
            received++;
          end else if (pv) begin
            chk32("rnd_hold_data", data_s, pd);
            chk1("rnd_hold_valid", valid_s, 1'b1);
          end
          if (ack_s != pa) acks++;
          if (!mode) chk1("rnd_ack_on_accept", ack_s != pa, pv && pr);
        end
        if (received < nw) begin
          chk32("rnd_sink_timeout", 32'(received), 32'(nw));
          abort = 1'b1;
        end
      end
    join
    chk32("rnd_ack_count", 32'(acks), 32'(nw));
    chk32("rnd_leftover", 32'(exp_q.size()), 32'd0);
    ready_i = 1'b0;
  endtask

  initial begin
    int n;
    mode_sel = 1'b0;

    tbl[0]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0};

    // Outputs stay at reset values while req toggles under reset.
    rst_n   = 1'b0;
    req_i   = 1'b0;
    ready_i = 1'b1;
    data_i  = 32'h55AA55AA;
    for (int i = 0; i < 6; i++) begin
      req_i = ~req_i;
      step();
      chk1("rst_valid0", valid0, 1'b0);
      chk1("rst_ack0", ack0, 1'b0);
      chk32("rst_data0", data0, 32'h0);
      chk1("rst_valid1", valid1, 1'b0);
      chk1("rst_ack1", ack1, 1'b0);
    end
    do_reset();

    for (int i = 0; i < 15; i++) begin
      req_i   = tbl[i].req;
      data_i  = tbl[i].data;
      ready_i = tbl[i].ready;
      step();
      chk1($sformatf("vec%0d_valid0", i), valid0, tbl[i].exp_valid);
      chk32($sformatf("vec%0d_data0", i), data0, tbl[i].exp_data);
      chk1($sformatf("vec%0d_ack0", i), ack0, tbl[i].exp_ack0);
      chk1($sformatf("vec%0d_valid1", i), valid1, tbl[i].exp_valid);
      chk32($sformatf("vec%0d_data1", i), data1, tbl[i].exp_data);
      chk1($sformatf("vec%0d_ack1", i), ack1, tbl[i].exp_ack1);
    end

    // Long backpressure on the mode-0 receiver.
    req_i   = 1'b1;
    data_i  = 32'hA5A55A5A;
    ready_i = 1'b0;
    wait_valid(1'b0, n);
    chk32("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 20; i++) begin
      data_i = $urandom;
      step();
      chk1("bp_valid", valid0, 1'b1);
      chk32("bp_data", data0, 32'hA5A55A5A);
      chk1("bp_ack", ack0, 1'b0);
    end
    ready_i = 1'b1;
    step();
    chk1("bp_accept_ack", ack0, 1'b1);
    chk1("bp_accept_valid", valid0, 1'b0);
    ready_i = 1'b0;

    // Early-ack mode: the second word is taken on the accept edge of the first.
    do_reset();
    data_i = 32'h1;
    req_i  = 1'b1;
    wait_valid(1'b1, n);
    chk32("ac_first_data", data1, 32'h1);
    chk1("ac_first_ack", ack1, 1'b1);
    data_i = 32'h2;
    req_i  = 1'b0;
    repeat (5) step();
    chk32("ac_hold_data", data1, 32'h1);
    chk1("ac_hold_valid", valid1, 1'b1);
    chk1("ac_hold_ack", ack1, 1'b1);
    ready_i = 1'b1;
    step();
    chk32("ac_b2b_data", data1, 32'h2);
    chk1("ac_b2b_valid", valid1, 1'b1);
    chk1("ac_b2b_ack", ack1, 1'b0);
    step();
    chk1("ac_drain_valid", valid1, 1'b0);
    chk1("ac_drain_ack", ack1, 1'b0);
    chk32("ac_drain_data", data1, 32'h2);
    ready_i = 1'b0;

    // Reset while a word is presented.
    do_reset();
    data_i = 32'h77;
    req_i  = 1'b1;
    wait_valid(1'b1, n);
    chk1("mr_pre_valid0", valid0, 1'b1);
    chk1("mr_pre_ack1", ack1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mr_valid0", valid0, 1'b0);
    chk1("mr_valid1", valid1, 1'b0);
    chk1("mr_ack1", ack1, 1'b0);
    chk32("mr_data0", data0, 32'h0);
    req_i = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk1("mr_post_valid0", valid0, 1'b0);
      chk1("mr_post_valid1", valid1, 1'b0);
      chk1("mr_post_ack0", ack0, 1'b0);
      chk1("mr_post_ack1", ack1, 1'b0);
    end

    run_random(1'b0, 1000);
    run_random(1'b1, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_handshake_receiver
